// File: rtl/fifo_video_timing_reader.sv
// rtl/fifo_video_timing_reader.sv - 1080p raster timing generator that drains the async pixel FIFO
//
// Read-clock-domain consumer of the pixel FIFO. Once the FIFO reports it is
// pre-filled (almost_empty low), the raster runs freely. One word is read per
// active pixel, and timing-aligned RGB is presented to the HDMI stage.
//
// Ports:
//   rd_clk, rd_rst      pixel clock, async active-high reset
//   rd_en               FIFO read enable (combinational from stage 0)
//   rd_data             FIFO word, valid the cycle after rd_en
//   rd_empty            FIFO empty
//   almost_empty        FIFO almost empty; low = pre-fill complete
//   vid_hs/vs/de/data   registered video outputs, 2 cycles behind the counters
//   vid_sof             pulse on the first active pixel of each frame
//   underflow           sticky starvation flag
//   underflow_cnt       starved pixels in the previous frame (saturating)
module fifo_video_timing_reader #(
  parameter int DATA_WIDTH = 24,
  parameter int H_ACTIVE   = 1920,
  parameter int H_FP       = 88,
  parameter int H_SYNC     = 44,
  parameter int H_BP       = 148,
  parameter int V_ACTIVE   = 1080,
  parameter int V_FP       = 4,
  parameter int V_SYNC     = 5,
  parameter int V_BP       = 36,
  parameter int SYNC_POL   = 1
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_empty,
  input  logic                  almost_empty,
  output logic                  vid_hs,
  output logic                  vid_vs,
  output logic                  vid_de,
  output logic [DATA_WIDTH-1:0] vid_data,
  output logic                  vid_sof,
  output logic                  underflow,
  output logic [15:0]           underflow_cnt
);

  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] H_LAST   = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] V_LAST   = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic        SYNC_ACT = (SYNC_POL != 0);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_next;
  logic        run;
  logic [11:0] h_cnt;
  logic [10:0] v_cnt;
  logic        de0, hs0, vs0, sof0, starve0;
  logic        de1, hs1, vs1, sof1, starve1;
  logic [15:0] frame_cnt;

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    run        = 1'b0;
    case (state)
      IDLE: if (!almost_empty) state_next = RUN;
      RUN:  run = 1'b1;
      default: state_next = IDLE;
    endcase
  end

  // Counters sit at 0 in IDLE so the first RUN cycle starts the frame at 0,0.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!run) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? 11'd0 : v_cnt + 11'd1;
    end else begin
      h_cnt <= h_cnt + 12'd1;
    end
  end

  // Stage 0: decode gated by run, since the counters also read 0,0 in IDLE.
  always_comb begin
    de0     = run && (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs0     = run && (h_cnt >= HS_START) && (h_cnt < HS_END);
    vs0     = run && (v_cnt >= VS_START) && (v_cnt < VS_END);
    sof0    = de0 && (h_cnt == 12'd0) && (v_cnt == 11'd0);
    starve0 = de0 && rd_empty;
    rd_en   = de0 && !rd_empty;
  end

  // Stage 1: the FIFO word read in stage 0 is on rd_data during this stage.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      de1     <= 1'b0;
      hs1     <= 1'b0;
      vs1     <= 1'b0;
      sof1    <= 1'b0;
      starve1 <= 1'b0;
    end else begin
      de1     <= de0;
      hs1     <= hs0;
      vs1     <= vs0;
      sof1    <= sof0;
      starve1 <= starve0;
    end
  end

  // Stage 2: registered outputs; starved pixels are forced to black.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      vid_de   <= 1'b0;
      vid_sof  <= 1'b0;
      vid_hs   <= !SYNC_ACT;
      vid_vs   <= !SYNC_ACT;
      vid_data <= '0;
    end else begin
      vid_de   <= de1;
      vid_sof  <= sof1;
      vid_hs   <= hs1 ? SYNC_ACT : !SYNC_ACT;
      vid_vs   <= vs1 ? SYNC_ACT : !SYNC_ACT;
      vid_data <= (de1 && !starve1) ? rd_data : '0;
    end
  end

  // Per-frame starvation count; the sof pixel itself belongs to the new frame.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      frame_cnt     <= '0;
      underflow_cnt <= '0;
      underflow     <= 1'b0;
    end else begin
      if (starve0) underflow <= 1'b1;
      if (sof0) begin
        underflow_cnt <= frame_cnt;
        frame_cnt     <= {15'd0, starve0};
      end else if (starve0 && (frame_cnt != 16'hFFFF)) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_video_timing_reader.sv
// tb/tb_fifo_video_timing_reader.sv - directed bench for fifo_video_timing_reader
module tb_fifo_video_timing_reader;

  localparam int HT   = 14;
  localparam int FT   = 98;
  localparam int NREC = 3 * FT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        rd_empty = 1'b0;
  logic        almost_empty = 1'b1;
  logic [23:0] rd_data = '0;
  logic [23:0] word = 24'd1;

  logic        rd_en, vid_hs, vid_vs, vid_de, vid_sof, underflow;
  logic [23:0] vid_data;
  logic [15:0] underflow_cnt;

  logic        p_rd_en, p_hs, p_vs, p_de, p_sof, p_uf;
  logic [23:0] p_data;
  logic [15:0] p_ucnt;

  logic        s_rst = 1'b1;
  logic        s_rd_en, s_hs, s_vs, s_de, s_sof, s_uf;
  logic [23:0] s_data;
  logic [15:0] s_ucnt;

  int n_tests = 0;
  int n_fail  = 0;

  fifo_video_timing_reader #(
    .DATA_WIDTH(24), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1)
  ) u_dut (
    .rd_clk(clk), .rd_rst(rst), .rd_en(rd_en), .rd_data(rd_data),
    .rd_empty(rd_empty), .almost_empty(almost_empty),
    .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_de(vid_de), .vid_data(vid_data),
    .vid_sof(vid_sof), .underflow(underflow), .underflow_cnt(underflow_cnt)
  );

  fifo_video_timing_reader #(
    .DATA_WIDTH(24), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(0)
  ) u_pol (
    .rd_clk(clk), .rd_rst(rst), .rd_en(p_rd_en), .rd_data(rd_data),
    .rd_empty(rd_empty), .almost_empty(almost_empty),
    .vid_hs(p_hs), .vid_vs(p_vs), .vid_de(p_de), .vid_data(p_data),
    .vid_sof(p_sof), .underflow(p_uf), .underflow_cnt(p_ucnt)
  );

  fifo_video_timing_reader #(
    .DATA_WIDTH(24), .H_ACTIVE(256), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(256), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1)
  ) u_sat (
    .rd_clk(clk), .rd_rst(s_rst), .rd_en(s_rd_en), .rd_data(24'd0),
    .rd_empty(1'b1), .almost_empty(1'b0),
    .vid_hs(s_hs), .vid_vs(s_vs), .vid_de(s_de), .vid_data(s_data),
    .vid_sof(s_sof), .underflow(s_uf), .underflow_cnt(s_ucnt)
  );

  // FIFO model without output register: word appears the cycle after rd_en.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data <= word;
      word    <= word + 24'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic        rd_a [NREC];
  logic        de_a [NREC];
  logic        hs_a [NREC];
  logic        vs_a [NREC];
  logic        sof_a[NREC];
  logic        uf_a [NREC];
  logic        phs_a[NREC];
  logic        pvs_a[NREC];
  logic        pde_a[NREC];
  int          dat_a[NREC];
  int          ucnt_a[NREC];

  task automatic main_seq();
    logic acc, acc_p;
    int wv[NREC];
    logic act[NREC];
    int nw, h, l, tt;
    int b_rd, b_de, b_dat, b_hs, b_vs, b_sof, b_phs, b_pvs, b_pde, n_rd1, n_rd3;
    logic e_de, e_hs, e_vs, e_sof;
    int e_dat;

    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_en", rd_en, 0);
    check("rst_de", vid_de, 0);
    check("rst_hs", vid_hs, 0);
    check("rst_pol_hs", p_hs, 1);
    rst = 1'b0;

    acc = 1'b0;
    acc_p = 1'b1;
    repeat (50) begin
      @(posedge clk); #2;
      acc   = acc | rd_en | vid_de | vid_hs | vid_vs | vid_sof;
      acc_p = acc_p & p_hs & p_vs;
    end
    check("prefill_idle", acc, 0);
    check("prefill_pol_idle", acc_p, 1);

    @(posedge clk); #1;
    almost_empty = 1'b0;
    #1;
    check("rd_en_before_run", rd_en, 0);

    for (int t = 0; t < NREC; t++) begin
      @(posedge clk); #1;
      rd_empty = (t == 101 || t == 102);
      #1;
      rd_a[t] = rd_en;   de_a[t] = vid_de;  hs_a[t] = vid_hs;  vs_a[t] = vid_vs;
      sof_a[t] = vid_sof; uf_a[t] = underflow; dat_a[t] = int'(vid_data);
      ucnt_a[t] = int'(underflow_cnt);
      phs_a[t] = p_hs; pvs_a[t] = p_vs; pde_a[t] = p_de;
    end

    // Reference raster: stage-0 expectations per cycle, outputs 2 cycles later.
    nw = 1;
    for (int t = 0; t < NREC; t++) begin
      h = t % HT;
      l = (t / HT) % 7;
      act[t] = (h < 8) && (l < 4);
      if (act[t] && !(t == 101 || t == 102)) begin
        wv[t] = nw;
        nw++;
      end else begin
        wv[t] = 0;
      end
    end
    b_rd = 0; b_de = 0; b_dat = 0; b_hs = 0; b_vs = 0; b_sof = 0;
    b_phs = 0; b_pvs = 0; b_pde = 0; n_rd1 = 0; n_rd3 = 0;
    for (int t = 0; t < NREC; t++) begin
      tt = t - 2;
      e_de  = (tt >= 0) && act[tt];
      e_dat = (tt >= 0) ? wv[tt] : 0;
      e_hs  = (tt >= 0) && ((tt % HT) == 10 || (tt % HT) == 11);
      e_vs  = (tt >= 0) && (((tt / HT) % 7) == 5);
      e_sof = (tt >= 0) && ((tt % FT) == 0);
      if (rd_a[t] != (act[t] && wv[t] != 0)) b_rd++;
      if (de_a[t] != e_de) b_de++;
      if (dat_a[t] != e_dat) b_dat++;
      if (hs_a[t] != e_hs) b_hs++;
      if (vs_a[t] != e_vs) b_vs++;
      if (sof_a[t] != e_sof) b_sof++;
      if (phs_a[t] != !e_hs) b_phs++;
      if (pvs_a[t] != !e_vs) b_pvs++;
      if (pde_a[t] != e_de) b_pde++;
      if (t < FT && rd_a[t]) n_rd1++;
      if (t >= 2 * FT && rd_a[t]) n_rd3++;
    end
    check("rd_en_pattern_errs", b_rd, 0);
    check("de_pattern_errs", b_de, 0);
    check("data_pattern_errs", b_dat, 0);
    check("hs_pattern_errs", b_hs, 0);
    check("vs_pattern_errs", b_vs, 0);
    check("sof_pattern_errs", b_sof, 0);
    check("pol_hs_errs", b_phs, 0);
    check("pol_vs_errs", b_pvs, 0);
    check("pol_de_errs", b_pde, 0);

    check("first_rd_en", rd_a[0], 1);
    check("de_lat_t1", de_a[1], 0);
    check("de_lat_t2", de_a[2], 1);
    check("sof_lat_t2", sof_a[2], 1);
    check("data_first", dat_a[2], 1);
    check("data_last_f1", dat_a[51], 32);
    check("reads_frame1", n_rd1, 32);
    check("reads_frame3", n_rd3, 32);
    check("hs_t11", hs_a[11], 0);
    check("hs_t12", hs_a[12], 1);
    check("hs_t13", hs_a[13], 1);
    check("hs_t14", hs_a[14], 0);
    check("vs_t71", vs_a[71], 0);
    check("vs_t72", vs_a[72], 1);
    check("vs_t85", vs_a[85], 1);
    check("vs_t86", vs_a[86], 0);
    check("pol_hs_t12", phs_a[12], 0);
    check("starve_rd_en_p3", rd_a[101], 0);
    check("starve_rd_en_p4", rd_a[102], 0);
    check("starve_rd_en_p5", rd_a[103], 1);
    check("starve_de", de_a[103], 1);
    check("starve_data_p3", dat_a[103], 0);
    check("starve_data_p4", dat_a[104], 0);
    check("resume_data_p5", dat_a[105], 36);
    check("underflow_before", uf_a[100], 0);
    check("underflow_after", uf_a[103], 1);
    check("ucnt_frame1", ucnt_a[150], 0);
    check("ucnt_frame2_sof", sof_a[198], 1);
    check("ucnt_frame2", ucnt_a[198], 2);

    // Mid-frame reset at line 2, pixel 5 of the fourth frame.
    for (int t = NREC; t <= NREC + 2 * HT + 5; t++) begin
      @(posedge clk); #2;
    end
    check("pre_rst_de", vid_de, 1);
    check("pre_rst_rd_en", rd_en, 1);
    rst = 1'b1;
    #1;
    check("async_rst_rd_en", rd_en, 0);
    check("async_rst_de", vid_de, 0);
    check("async_rst_data", vid_data, 0);
    check("async_rst_uf", underflow, 0);
    check("async_rst_ucnt", underflow_cnt, 0);
    check("async_rst_pol_hs", p_hs, 1);
    almost_empty = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    acc = 1'b0;
    repeat (10) begin
      @(posedge clk); #2;
      acc = acc | rd_en | vid_de;
    end
    check("restart_hold", acc, 0);
    @(posedge clk); #1;
    almost_empty = 1'b0;
    #1;
    check("restart_rd_en_before", rd_en, 0);
    @(posedge clk); #2;
    check("restart_rd_en", rd_en, 1);
  endtask

  task automatic sat_seq();
    int cyc, nrd, nsof, nde;
    repeat (3) @(posedge clk);
    #1 s_rst = 1'b0;
    cyc = 0; nrd = 0; nsof = 0; nde = 0;
    while (nsof < 2 && cyc < 70000) begin
      @(posedge clk); #3;
      cyc++;
      nrd += int'(s_rd_en);
      nde += int'(s_de);
      if (s_sof) nsof++;
    end
    check("sat_sof_seen", nsof, 2);
    check("sat_ucnt", s_ucnt, 32'h0000FFFF);
    check("sat_no_rd_en", nrd, 0);
    check("sat_de_count", nde, 65537);
    check("sat_underflow", s_uf, 1);
  endtask

  initial begin
    fork
      main_seq();
      sat_seq();
    join
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_video_timing_reader.md
# fifo_video_timing_reader

Read-side consumer of the 24-bit, 4096-deep asynchronous pixel FIFO in the 1080p SFP video path. Runs entirely in the FIFO read clock domain. Generates 1080p60 raster timing (hsync, vsync, data-enable), pulls one pixel from the FIFO per active pixel, and presents timing-aligned RGB to the HDMI output stage. Starts the raster only once the FIFO has pre-filled. On starvation it substitutes black pixels and counts them.

## Interface
Parameters:
- DATA_WIDTH, 24, pixel width; must equal FIFO read width
- H_ACTIVE, 1920, active pixels per line
- H_FP, 88, horizontal front porch
- H_SYNC, 44, hsync width
- H_BP, 148, horizontal back porch
- V_ACTIVE, 1080, active lines per frame
- V_FP, 4, vertical front porch
- V_SYNC, 5, vsync width
- V_BP, 36, vertical back porch
- SYNC_POL, 1, sync polarity: 1 = active-high, 0 = active-low

Ports:
- rd_clk  in  1  read/pixel clock (148.5 MHz); the only clock
- rd_rst  in  1  asynchronous, active-high reset
- rd_en  out  1  FIFO read enable
- rd_data  in  DATA_WIDTH  FIFO read data; valid the cycle after rd_en (FIFO has no output register)
- rd_empty  in  1  FIFO empty
- almost_empty  in  1  FIFO almost empty (threshold 4 words)
- vid_hs  out  1  horizontal sync
- vid_vs  out  1  vertical sync
- vid_de  out  1  data enable
- vid_data  out  DATA_WIDTH  pixel data; 0 when vid_de = 0 or the pixel is starved
- vid_sof  out  1  one-cycle pulse coincident with the first active pixel of each frame
- underflow  out  1  sticky flag; set by any starved pixel; cleared only by rd_rst
- underflow_cnt  out  16  starved pixels in the previous frame; saturates at 16'hFFFF

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (2200). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (1125).
- Counters h_cnt [11:0] and v_cnt [10:0].
  - h_cnt wraps H_TOTAL-1 -> 0 and increments v_cnt.
  - v_cnt wraps V_TOTAL-1 -> 0.
- State machine:
  - IDLE (reset state): counters held at 0; rd_en = 0; all video outputs inactive.
  - IDLE -> RUN on the first cycle with almost_empty = 0. The first RUN cycle has h_cnt = v_cnt = 0.
  - RUN: counters free-run. No return to IDLE except via rd_rst.
- Stage-0 decode, from the counters:
  - de0 = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE)
  - hs0 active for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC
  - vs0 active for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC
  - sof0 = de0 && h_cnt == 0 && v_cnt == 0
- Read issue: rd_en = de0 && !rd_empty (combinational from registered state and rd_empty).
- Starved pixel: de0 && rd_empty. No read is issued, and a starve marker travels with the pixel.
- Never read from an empty FIFO. Never read outside de0.
- Starvation count:
  - A per-frame counter increments, saturating, on each starved pixel.
  - On sof0 it is transferred to underflow_cnt and cleared; the count for the current sof0 pixel is included in the new frame.

## Timing
- Two-stage pipeline from stage 0 to the outputs.
  - Stage 1: rd_data becomes valid.
  - Stage 2: registered outputs.
- vid_hs, vid_vs, vid_de, vid_sof and vid_data all lag the counters by exactly 2 cycles and are mutually aligned.
- vid_data = rd_data captured at stage 1 when de1 && !starve1; otherwise 0.
- Reset values (asynchronous):
  - vid_de = 0, vid_sof = 0, rd_en = 0, vid_data = 0
  - vid_hs = vid_vs = !SYNC_POL (inactive level)
  - underflow = 0, underflow_cnt = 0, state = IDLE
- Throughput in RUN: one pixel per clock during active video; exactly H_ACTIVE reads per line when the FIFO never empties.
- rd_empty asserting mid-line: only the affected pixels are black; later pixels resume reading when rd_empty deasserts. There is no realignment, so picture shift is accepted.
- rd_rst mid-frame: immediate return to IDLE with reset output values; restart waits for almost_empty = 0 again.
- Sync polarity: with SYNC_POL = 0, the sync outputs are inverted; de is always active-high.

## Test plan
Use reduced parameters for the bench: H 8/2/2/2 (H_TOTAL 14), V 4/1/1/1 (V_TOTAL 7).
- Pre-fill hold: reset, hold almost_empty = 1 for 50 cycles -> rd_en = 0, vid_de = 0, vid_hs/vid_vs inactive; drop almost_empty -> first rd_en on the next cycle; vid_de and vid_sof rise 2 cycles after the first rd_en.
- Full frame: FIFO model holds 0x000001.. incrementing and never empties -> 32 reads per frame; vid_data sequence is 1..32 in order on vid_de; hsync high for 2 cycles starting 10 cycles after line start; vsync high during line 5; underflow = 0.
- Starvation: force rd_empty = 1 for pixels 3-4 of line 0 -> rd_en low for those two cycles; vid_data = 0 at those de positions; the next pixel shows the next FIFO word; underflow = 1; underflow_cnt = 2 after the next vid_sof.
- Saturation: rd_empty held high for 70000 active pixels with full-size parameters -> underflow_cnt = 16'hFFFF; no rd_en pulses.
- Mid-frame reset: assert rd_rst at line 2, pixel 5 -> all outputs at reset values within the same cycle (asynchronously); restart only after almost_empty = 0.
- Polarity: SYNC_POL = 0 -> vid_hs/vid_vs idle high and pulse low at the same counts as the full-frame scenario; de unchanged.
